// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary adder front end.
// Holds the serializer state encoding, default frame lengths and the output bundle.
package unary_pkg;

    localparam int unsigned UNARY_FRAME_LEN = 15;
    localparam int unsigned UNARY_WRITE_LEN = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } ser_state_t;

    // Registered output bundle driven toward the adder and the operand source
    typedef struct packed {
        logic a;
        logic b;
        logic en;
        logic read_or_write;
        logic busy;
        logic in_ready;
        logic done;
    } ser_out_t;

    function automatic int unsigned unary_sat(input int unsigned val, input int unsigned max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/unary_therm_bit.sv
// One thermometer-code stream bit: high while the frame position is below the operand.
module unary_therm_bit #(
    parameter int unsigned CW = 5,
    parameter int unsigned VW = 4
) (
    input  logic [CW-1:0] cnt,
    input  logic [VW-1:0] val,
    output logic          bit_c
);

    localparam int unsigned MW = (CW > VW) ? CW : VW;

    assign bit_c = MW'(cnt) < MW'(val);

endmodule

// File: rtl/unary_operand_serializer.sv
// Converts a binary operand pair into fixed-length thermometer frames for the unary adder,
// then holds the adder in write mode for a drain window and pulses done.
module unary_operand_serializer
    import unary_pkg::*;
#(
    parameter int unsigned FRAME_LEN = UNARY_FRAME_LEN,
    parameter int unsigned W         = 4,
    parameter int unsigned WRITE_LEN = UNARY_WRITE_LEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_val,
    input  logic [W-1:0] b_val,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CNT_MAX = (FRAME_LEN > WRITE_LEN) ? FRAME_LEN : WRITE_LEN;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] READ_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] WRITE_LAST = CW'(WRITE_LEN - 1);

    ser_state_t     state_q;
    ser_state_t     state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   a_d;
    logic [W-1:0]   b_q;
    logic [W-1:0]   b_d;
    ser_out_t       out_q;
    ser_out_t       out_d;
    logic           accept;
    logic           a_bit;
    logic           b_bit;

    assign accept = in_valid & out_q.in_ready;

    // State, counter and operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state, counter and operand capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                    cnt_d   = '0;
                    a_d     = W'(unary_sat(32'(a_val), FRAME_LEN));
                    b_d     = W'(unary_sat(32'(b_val), FRAME_LEN));
                end
            end
            READ: begin
                if (cnt_q == READ_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stream bits are computed from next-cycle values so the registered outputs line up
    unary_therm_bit #(
        .CW (CW),
        .VW (W)
    ) u_therm_a (
        .cnt   (cnt_d),
        .val   (a_d),
        .bit_c (a_bit)
    );

    unary_therm_bit #(
        .CW (CW),
        .VW (W)
    ) u_therm_b (
        .cnt   (cnt_d),
        .val   (b_d),
        .bit_c (b_bit)
    );

    // Output decode for the cycle after this edge
    always_comb begin
        out_d = '0;
        unique case (state_d)
            IDLE: begin
                out_d.in_ready = 1'b1;
                out_d.done     = (state_q == WRITE);
            end
            READ: begin
                out_d.a    = a_bit;
                out_d.b    = b_bit;
                out_d.en   = 1'b1;
                out_d.busy = 1'b1;
            end
            WRITE: begin
                out_d.en            = 1'b1;
                out_d.read_or_write = 1'b1;
                out_d.busy          = 1'b1;
            end
            default: begin
                out_d.in_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q          <= '0;
            out_q.in_ready <= 1'b1;
        end else begin
            out_q <= out_d;
        end
    end

    assign A             = out_q.a;
    assign B             = out_q.b;
    assign en            = out_q.en;
    assign read_or_write = out_q.read_or_write;
    assign busy          = out_q.busy;
    assign in_ready      = out_q.in_ready;
    assign done          = out_q.done;

endmodule

// File: tb/tb_unary_operand_serializer.sv
// Bench for unary_operand_serializer: table vectors, directed corner sequences and random
// traffic, all checked cycle by cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_unary_operand_serializer;

    localparam int FL   = 15;
    localparam int FL10 = 10;
    localparam int WL   = 20;

    typedef struct packed {
        logic a;
        logic b;
        logic en;
        logic rw;
        logic busy;
        logic rdy;
        logic done;
    } obs_t;

    typedef struct {
        int sel;
        int a;
        int b;
        int na;
        int nb;
        int rw_first;
        int nrw;
        int done_at;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, v10;
    logic [3:0] a_val, b_val, a10, b10;
    logic A, B, en, read_or_write, busy, done, in_ready;
    logic A10, B10, en10, rw10, busy10, done10, rdy10;

    always #5 clk = ~clk;

    unary_operand_serializer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_val(a_val), .b_val(b_val), .A(A), .B(B), .en(en),
        .read_or_write(read_or_write), .busy(busy), .done(done)
    );

    unary_operand_serializer #(.FRAME_LEN(FL10), .W(4), .WRITE_LEN(WL)) dut10 (
        .clk(clk), .rst(rst), .in_valid(v10), .in_ready(rdy10),
        .a_val(a10), .b_val(b10), .A(A10), .B(B10), .en(en10),
        .read_or_write(rw10), .busy(busy10), .done(done10)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    obs_t act0, act1;
    assign act0 = {A, B, en, read_or_write, busy, in_ready, done};
    assign act1 = {A10, B10, en10, rw10, busy10, rdy10, done10};

    function automatic obs_t idle_obs();
        obs_t r;
        r = '0;
        r.rdy = 1'b1;
        return r;
    endfunction

    // Expected outputs for position i of a transaction (0 = first cycle after accept)
    function automatic obs_t txn_rec(int i, int fl, int wl, int sa, int sb);
        obs_t r;
        r = '0;
        if (i < fl) begin
            r.a = (i < sa); r.b = (i < sb); r.en = 1'b1; r.busy = 1'b1;
        end else if (i < fl + wl) begin
            r.en = 1'b1; r.rw = 1'b1; r.busy = 1'b1;
        end else begin
            r.rdy = 1'b1; r.done = 1'b1;
        end
        return r;
    endfunction

    // Reference model: an accepted pair enqueues its whole future output sequence
    obs_t q0[$];
    obs_t q1[$];
    obs_t exp0, exp1;
    int   ai0, bi0, ai1, bi1;

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            exp0 = idle_obs();
        end else begin
            if (q0.size() == 0 && in_valid) begin
                ai0 = a_val; bi0 = b_val;
                if (ai0 > FL) ai0 = FL;
                if (bi0 > FL) bi0 = FL;
                for (int i = 0; i <= FL + WL; i++) q0.push_back(txn_rec(i, FL, WL, ai0, bi0));
            end
            if (q0.size() > 0) exp0 = q0.pop_front();
            else               exp0 = idle_obs();
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q1.delete();
            exp1 = idle_obs();
        end else begin
            if (q1.size() == 0 && v10) begin
                ai1 = a10; bi1 = b10;
                if (ai1 > FL10) ai1 = FL10;
                if (bi1 > FL10) bi1 = FL10;
                for (int i = 0; i <= FL10 + WL; i++) q1.push_back(txn_rec(i, FL10, WL, ai1, bi1));
            end
            if (q1.size() > 0) exp1 = q1.pop_front();
            else               exp1 = idle_obs();
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare both DUTs against the model on the falling edge
    task automatic tick();
        @(negedge clk);
        if (chk_on) begin
            n_cmp++;
            if (act0 !== exp0) begin
                n_bad++;
                $display("FAIL stream15 t=%0t: got %b, want %b", $time, act0, exp0);
            end
            n_cmp++;
            if (act1 !== exp1) begin
                n_bad++;
                $display("FAIL stream10 t=%0t: got %b, want %b", $time, act1, exp1);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int na, nb, nrw, rwf, dat;
        logic sa, sb, srw, sd;
        na = 0; nb = 0; nrw = 0; rwf = -1; dat = -1;
        if (v.sel == 0) begin in_valid = 1'b1; a_val = 4'(v.a); b_val = 4'(v.b); end
        else            begin v10 = 1'b1; a10 = 4'(v.a); b10 = 4'(v.b); end
        tick();
        in_valid = 1'b0; v10 = 1'b0;
        for (int k = 1; k <= FL + WL + 2; k++) begin
            sa  = (v.sel == 0) ? A : A10;
            sb  = (v.sel == 0) ? B : B10;
            srw = (v.sel == 0) ? read_or_write : rw10;
            sd  = (v.sel == 0) ? done : done10;
            if (sa) na++;
            if (sb) nb++;
            if (srw) begin nrw++; if (rwf < 0) rwf = k; end
            if (sd && dat < 0) dat = k;
            tick();
        end
        check($sformatf("vec%0d A ones", idx), na, v.na);
        check($sformatf("vec%0d B ones", idx), nb, v.nb);
        check($sformatf("vec%0d rw first cycle", idx), rwf, v.rw_first);
        check($sformatf("vec%0d rw length", idx), nrw, v.nrw);
        check($sformatf("vec%0d done cycle", idx), dat, v.done_at);
    endtask

    vec_t tbl[6];
    int   cnt_a, cnt_zero, done_seen, dat;

    initial begin
        tbl[0] = '{0, 7, 4, 7, 4, 16, 20, 36};
        tbl[1] = '{0, 0, 15, 0, 15, 16, 20, 36};
        tbl[2] = '{0, 15, 0, 15, 0, 16, 20, 36};
        tbl[3] = '{0, 1, 14, 1, 14, 16, 20, 36};
        tbl[4] = '{1, 14, 3, 10, 3, 11, 20, 31};
        tbl[5] = '{1, 10, 0, 10, 0, 11, 20, 31};

        rst = 1'b1; in_valid = 1'b0; v10 = 1'b0;
        a_val = '0; b_val = '0; a10 = '0; b10 = '0;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        check("reset in_ready", int'(in_ready), 1);
        check("reset en", int'(en), 0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Reset and in_valid together: nothing accepted
        rst = 1'b1; in_valid = 1'b1; a_val = 4'd9; b_val = 4'd9;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("rst+valid en", int'(en), 0);
        check("rst+valid in_ready", int'(in_ready), 1);

        // Back-to-back: valid held, operands changed while busy, second accept on done
        in_valid = 1'b1; a_val = 4'd5; b_val = 4'd9;
        tick();
        a_val = 4'd2; b_val = 4'd12;
        cnt_a = 0; cnt_zero = 0; dat = -1;
        for (int k = 1; k <= FL + WL + 1; k++) begin
            if (A && k <= FL) cnt_a++;
            if (!en) cnt_zero++;
            if (done && dat < 0) dat = k;
            tick();
        end
        check("b2b first A ones", cnt_a, 5);
        check("b2b done cycle", dat, FL + WL + 1);
        check("b2b idle gap", cnt_zero, 1);
        check("b2b second frame en", int'(en), 1);
        check("b2b second frame A bit0", int'(A), 1);
        in_valid = 1'b0;
        for (int k = 0; k < FL + WL + 2; k++) tick();

        // Reset on READ cycle 5
        in_valid = 1'b1; a_val = 4'd9; b_val = 4'd9;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset en", int'(en), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset in_ready", int'(in_ready), 1);
        done_seen = 0;
        for (int k = 0; k < FL + WL + 2; k++) begin
            if (done) done_seen++;
            tick();
        end
        check("midreset no done", done_seen, 0);
        run_vec(tbl[0], 10);

        // in_valid during WRITE is ignored
        in_valid = 1'b1; a_val = 4'd3; b_val = 4'd8;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < FL + 3; k++) tick();
        cnt_zero = 0;
        in_valid = 1'b1; a_val = 4'd15; b_val = 4'd15;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!in_ready) cnt_zero++;
        end
        in_valid = 1'b0;
        check("write-phase in_ready low", cnt_zero, 5);
        for (int k = 0; k < FL + WL; k++) tick();

        // Random traffic on both instances
        for (int k = 0; k < 2500; k++) begin
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) == 0);
            a_val    = 4'($urandom_range(0, 15));
            b_val    = 4'($urandom_range(0, 15));
            v10      = ($urandom_range(0, 2) == 0);
            a10      = 4'($urandom_range(0, 15));
            b10      = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; v10 = 1'b0;
        for (int k = 0; k < FL + WL + 3; k++) tick();
        check("final idle in_ready", int'(in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unary_operand_serializer.md
# unary_operand_serializer

Upstream feeder for the 1-4-7 unary adder. Accepts two binary operands through a valid/ready handshake and converts each into a thermometer-coded bitstream (N ones, then zeros) of fixed frame length on `A`/`B`, with `en` asserted. It then switches the adder into write mode (`read_or_write = 1`) for a fixed drain window so the adder can emit its unary sum on `dout`. Afterwards it returns to idle and signals completion.

## Interface
- `FRAME_LEN`, 15: cycles per read frame; also the maximum representable operand value.
- `W`, 4: operand width, equal to clog2(FRAME_LEN+1).
- `WRITE_LEN`, 20: cycles the write (drain) window is held.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a_val`  in  W  binary operand for stream A.
- `b_val`  in  W  binary operand for stream B.
- `A`  out  1  thermometer stream A, to adder `A`.
- `B`  out  1  thermometer stream B, to adder `B`.
- `en`  out  1  adder enable, to adder `en`.
- `read_or_write`  out  1  0 = read/accumulate, 1 = write/drain; to adder `read_or_write`.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle pulse at the end of a transaction.

## Operation
- Three states:
  - IDLE: `in_ready=1`. On `in_valid&in_ready`, latch both operands, clear the counter, go to READ.
  - READ: runs FRAME_LEN cycles, with counter `cnt` going 0..FRAME_LEN-1.
    - `A = (cnt < a_q)`, `B = (cnt < b_q)`, `en=1`, `read_or_write=0`.
    - At `cnt==FRAME_LEN-1`, clear the counter and go to WRITE.
  - WRITE: runs WRITE_LEN cycles.
    - `en=1`, `read_or_write=1`, `A=B=0`.
    - At `cnt==WRITE_LEN-1`, go to IDLE and assert `done`.
- Operand saturation: an operand greater than FRAME_LEN is latched as FRAME_LEN. This only matters when FRAME_LEN < 2^W-1.
- Operands are captured only at the handshake. `a_val`/`b_val` changing while busy has no effect.
- `in_valid` while busy is ignored. No queueing; the source holds `in_valid` until accepted.
- Counter width is clog2(max(FRAME_LEN, WRITE_LEN)). The counter never wraps except through an explicit clear.

## Timing
- All outputs are registered.
- Reset values: `A=0`, `B=0`, `en=0`, `read_or_write=0`, `in_ready=1`, `busy=0`, `done=0`; state IDLE, counter 0.
- Accept at edge t: from t+1, `en=1` and bit 0 of both streams is presented. READ occupies cycles t+1..t+FRAME_LEN.
- WRITE occupies cycles t+FRAME_LEN+1..t+FRAME_LEN+WRITE_LEN.
- In cycle t+FRAME_LEN+WRITE_LEN+1:
  - `done=1`, `in_ready=1`, `en=0`, `read_or_write=0`.
  - A new accept in this same cycle is legal, giving back-to-back frames with exactly one idle cycle (`en=0`) between them.
- Transaction length: FRAME_LEN+WRITE_LEN+1 cycles handshake-to-handshake.
- `rst` asserted mid-READ or mid-WRITE: on the next edge all outputs take their reset values. No `done` is produced and the latched operands are discarded.
- `rst` and `in_valid` high together: reset wins and nothing is accepted.

## Structure
- Shared package `unary_pkg`:
  - state enum `ser_state_t` {IDLE, READ, WRITE};
  - default constants `UNARY_FRAME_LEN=15`, `UNARY_WRITE_LEN=20`;
  - function `unary_sat(val, max)`.
- One natural sub-module: `unary_therm_bit`, a combinational compare `cnt < val` producing one stream bit. It is instantiated twice, for A and B.
- The FSM and counter live in the top module.

## Test plan
- Reset, then `a_val=7`, `b_val=4`:
  - `A` is 1 for 7 cycles then 0 for 8; `B` is 1 for 4 then 0 for 11; `en=1` throughout.
  - `read_or_write` rises on cycle 16 after the accept and stays high 20 cycles.
  - `done` pulses on cycle 36.
- `a_val=0`, `b_val=15`: `A=0` for the whole frame and `B=1` for all 15 cycles; WRITE and `done` timing are unchanged.
- With FRAME_LEN=10 and W=4, `a_val=14`: `A` is 1 for all 10 cycles (saturated); `B` follows `b_val=3` (3 ones).
- Back-to-back:
  - `in_valid` held high with `a_val` changed during busy: the second operand set is accepted exactly in the `done` cycle.
  - The first stream is unaffected, and there is exactly one `en=0` cycle between frames.
- `rst` pulsed on READ cycle 5: the next cycle shows every output at its reset value and `in_ready=1`, with no `done`. A subsequent accept produces a full, clean frame.
- `in_valid` asserted during WRITE: `in_ready` stays 0, nothing is latched, and the stream matches the golden pattern.
